reg_writeback_queue: RTL and testbench
======================================

// Module: reg_writeback_queue
// PURPOSE
// - Writer-side front end of the 32x32 register file: collects writeback requests from the
//   ALU stage and the memory (load) stage and buffers them in a small FIFO.
// - Drains one request per cycle onto the register file write port (regWrite/writeReg/writeData).
// - Bypass lookup lets decode read values that are still pending in the queue.
// PARAMETERS
// - DEPTH   4   FIFO entries; power of 2, >= 2
// - ADDR_W  5   register index width
// - DATA_W  32  register data width
// PORTS
// - Clk        in   1       system clock; all state updates on posedge
// - Reset_n    in   1       synchronous, active-low reset
// - memValid   in   1       memory-stage writeback request
// - memReg     in   ADDR_W  destination register of the memory-stage request
// - memData    in   DATA_W  data of the memory-stage request
// - aluValid   in   1       ALU-stage writeback request
// - aluReg     in   ADDR_W  destination register of the ALU-stage request
// - aluData    in   DATA_W  data of the ALU-stage request
// - inReady    out  1       1 = at least 2 free entries; requests are accepted this cycle
// - regWrite   out  1       register file write enable (= !empty)
// - writeReg   out  ADDR_W  head entry register index
// - writeData  out  DATA_W  head entry data
// - peekReg    in   ADDR_W  bypass lookup index
// - peekHit    out  1       peekReg matches a pending entry
// - peekData   out  DATA_W  data of the youngest matching pending entry
// - count      out  $clog2(DEPTH)+1  number of valid entries
// BEHAVIOUR
// - Reset (Reset_n=0 at posedge): head, tail and count cleared; regWrite=0, peekHit=0, count=0,
//   inReady=1. Reset mid-drain discards all pending entries; nothing further is written.
// - inReady = (DEPTH - count) >= 2. This is combinational from count and does not credit a
//   same-cycle dequeue.
// - Enqueue happens at posedge when inReady=1:
//   - the mem request (if valid) enters first, then the alu request (if valid);
//   - mem is older in program order, so it is always written first;
//   - requests with Reg==0 are discarded and consume no entry.
// - Requests presented while inReady=0 are dropped; the producer must stall upstream.
// - Drain:
//   - the write outputs are combinational from the head entry;
//   - the register file commits at negedge of the same cycle;
//   - the head pops at the next posedge whenever regWrite=1.
//   - Latency: a request enqueued at posedge N is written at the earliest in the cycle after N.
// - Count update: count_next = count + pushes(0..2) - pop(0/1). An empty queue with a
//   simultaneous push does not pop that same cycle.
// - Pointers wrap modulo DEPTH; there is no full/empty ambiguity because count is kept explicitly.
// - Bypass (combinational):
//   - searches the valid stored entries; the youngest match wins;
//   - same-cycle incoming requests are not searched;
//   - peekReg==0 or no match -> peekHit=0, peekData=0.
// - Widths: count is $clog2(DEPTH)+1 bits; all data paths are DATA_W bits with no arithmetic.
// CONFIGURATION
// - WBQ_OVERFLOW_ERR_EN defined:
//   - adds port overflowErr out 1;
//   - overflowErr is sticky, set at the posedge where a valid request (reg!=0) arrives
//     with inReady=0;
//   - cleared only by reset.
// - WBQ_OVERFLOW_ERR_EN undefined: the port is absent and drops are silent.
//   All other behaviour is identical.
// TESTING
// - Reset: Reset_n=0 for 2 cycles with both valids high -> regWrite=0, count=0, inReady=1,
//   peekHit=0.
// - Ordering: one cycle with mem(r3,0xAAAA0001) and alu(r3,0x00000002) ->
//   - next cycle writes r3=0xAAAA0001;
//   - the cycle after writes r3=0x00000002;
//   - meanwhile peekReg=3 -> peekData=0x00000002.
// - r0 filter: alu(r0,0xFFFFFFFF) only -> count stays 0, regWrite stays 0.
// - Fill (DEPTH=4), two requests per cycle:
//   - cycle 1: count goes 0 -> 2, then 1 pending after the drain; inReady drops once count>=3;
//   - stall until drained;
//   - writes appear in exact arrival order r1..r6 with matching data.
// - Overflow (macro on): hold count=3, send alu(r5,0x55) -> r5 is never written,
//   overflowErr=1 and stays 1 until reset.
// - Reset mid-operation: 3 entries pending, Reset_n=0 for one cycle -> regWrite=0 the next
//   cycle, count=0, and no further register writes.

Source files
------------

// File: rtl/reg_writeback_queue.sv
// reg_writeback_queue: writeback FIFO in front of the 32x32 register file.
// Takes mem (older) and ALU (younger) writeback requests, drains one per cycle
// onto the register file write port, and offers a youngest-match bypass lookup.
// Optional feature macro: WBQ_OVERFLOW_ERR_EN adds a sticky overflowErr output
// that flags requests dropped while inReady=0.
module reg_writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     memValid,
  input  logic [ADDR_W-1:0]        memReg,
  input  logic [DATA_W-1:0]        memData,
  input  logic                     aluValid,
  input  logic [ADDR_W-1:0]        aluReg,
  input  logic [DATA_W-1:0]        aluData,
  output logic                     inReady,
  output logic                     regWrite,
  output logic [ADDR_W-1:0]        writeReg,
  output logic [DATA_W-1:0]        writeData,
  input  logic [ADDR_W-1:0]        peekReg,
  output logic                     peekHit,
  output logic [DATA_W-1:0]        peekData,
  output logic [$clog2(DEPTH):0]   count
`ifdef WBQ_OVERFLOW_ERR_EN
  ,
  output logic                     overflowErr
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] regArr  [DEPTH];
  logic [DATA_W-1:0] dataArr [DEPTH];
  logic [PW-1:0]     head, tail, aluSlot;
  logic              memReq, aluReq, memPush, aluPush;

  // r0 writes are architectural no-ops, so they never become requests.
  assign memReq  = memValid && (memReg != '0);
  assign aluReq  = aluValid && (aluReg != '0);

  // Two free slots guarantee both requests fit without looking at the pop.
  assign inReady = (count <= CW'(DEPTH - 2));
  assign memPush = inReady && memReq;
  assign aluPush = inReady && aluReq;

  // ALU request lands behind the mem request when both are accepted.
  assign aluSlot = memPush ? tail + PW'(1) : tail;

  assign regWrite  = (count != '0);
  assign writeReg  = regArr[head];
  assign writeData = dataArr[head];

  // Entry storage: no reset needed, validity is tracked by count.
  always_ff @(posedge Clk) begin
    if (memPush) begin
      regArr[tail]  <= memReg;
      dataArr[tail] <= memData;
    end
    if (aluPush) begin
      regArr[aluSlot]  <= aluReg;
      dataArr[aluSlot] <= aluData;
    end
  end

  // Pointer and occupancy update; head pops whenever a write is presented.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (regWrite) head <= head + PW'(1);
      tail  <= tail + PW'(memPush) + PW'(aluPush);
      count <= count + CW'(memPush) + CW'(aluPush) - CW'(regWrite);
    end
  end

  // Bypass: walk entries oldest to youngest so the last match wins.
  always_comb begin
    peekHit  = 1'b0;
    peekData = '0;
    if (peekReg != '0) begin
      for (int i = 0; i < DEPTH; i++) begin
        if ((CW'(i) < count) && (regArr[head + PW'(i)] == peekReg)) begin
          peekHit  = 1'b1;
          peekData = dataArr[head + PW'(i)];
        end
      end
    end
  end

`ifdef WBQ_OVERFLOW_ERR_EN
  // Sticky flag for any real request that arrived while not ready.
  always_ff @(posedge Clk) begin
    if (!Reset_n)                        overflowErr <= 1'b0;
    else if (!inReady && (memReq || aluReq)) overflowErr <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Bench for reg_writeback_queue: queue-based reference model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_reg_writeback_queue;
  localparam int DEPTH = 4, AW = 5, DW = 32;

  logic          Clk = 0, Reset_n = 0;
  logic          memValid = 0, aluValid = 0;
  logic [AW-1:0] memReg = 0, aluReg = 0, peekReg = 0;
  logic [DW-1:0] memData = 0, aluData = 0;
  logic          inReady, regWrite, peekHit;
  logic [AW-1:0] writeReg;
  logic [DW-1:0] writeData, peekData;
  logic [$clog2(DEPTH):0] count;
`ifdef WBQ_OVERFLOW_ERR_EN
  logic          overflowErr;
`endif

  reg_writeback_queue #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .memValid(memValid), .memReg(memReg), .memData(memData),
    .aluValid(aluValid), .aluReg(aluReg), .aluData(aluData),
    .inReady(inReady), .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
    .peekReg(peekReg), .peekHit(peekHit), .peekData(peekData), .count(count)
`ifdef WBQ_OVERFLOW_ERR_EN
    , .overflowErr(overflowErr)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct { logic [AW-1:0] r; logic [DW-1:0] d; } ent_t;
  ent_t mq[$];     // model queue, index 0 = oldest
  ent_t wlog[$];   // writes observed at the register file port
  bit   mErr = 0;
  bit   chkEn = 0;
  int   vecs = 0, errs = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pending writes are just an ordered list.
  always @(posedge Clk) begin
    if (!Reset_n) begin
      mq.delete();
      mErr = 0;
    end else begin
      bit ready;
      ready = (DEPTH - mq.size()) >= 2;
      if (mq.size() > 0) void'(mq.pop_front());
      if (ready) begin
        if (memValid && memReg != 0) mq.push_back('{memReg, memData});
        if (aluValid && aluReg != 0) mq.push_back('{aluReg, aluData});
      end else if ((memValid && memReg != 0) || (aluValid && aluReg != 0)) begin
        mErr = 1;
      end
    end
  end

  // Every-cycle compare against the model, plus the register file commit log.
  always @(negedge Clk) begin
    if (regWrite === 1'b1) wlog.push_back('{writeReg, writeData});
    if (chkEn) begin
      bit hit; logic [DW-1:0] pd;
      hit = 0; pd = 0;
      if (peekReg != 0)
        for (int i = mq.size() - 1; i >= 0 && !hit; i--)
          if (mq[i].r == peekReg) begin hit = 1; pd = mq[i].d; end
      chk("m_count",    count,    mq.size());
      chk("m_regWrite", regWrite, mq.size() != 0);
      chk("m_inReady",  inReady,  (DEPTH - mq.size()) >= 2);
      if (mq.size() != 0) begin
        chk("m_writeReg",  writeReg,  mq[0].r);
        chk("m_writeData", writeData, mq[0].d);
      end
      chk("m_peekHit",  peekHit,  hit);
      chk("m_peekData", peekData, pd);
`ifdef WBQ_OVERFLOW_ERR_EN
      chk("m_overflowErr", overflowErr, mErr);
`endif
    end
  end

  task automatic tick(); @(posedge Clk); #1; endtask

  task automatic drive(input logic mv, input logic [AW-1:0] mr, input logic [DW-1:0] md,
                       input logic av, input logic [AW-1:0] ar, input logic [DW-1:0] ad);
    memValid = mv; memReg = mr; memData = md;
    aluValid = av; aluReg = ar; aluData = ad;
  endtask

  task automatic idle(); drive(0, 0, 0, 0, 0, 0); endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int idx;
    // Reset with both requests asserted
    drive(1, 5'd4, 32'h11, 1, 5'd6, 32'h22);
    peekReg = 3;
    Reset_n = 0;
    tick(); tick();
    chk("rst_regWrite", regWrite, 0);
    chk("rst_count",    count,    0);
    chk("rst_inReady",  inReady,  1);
    chk("rst_peekHit",  peekHit,  0);
    Reset_n = 1;
    idle();
    chkEn = 1;
    tick();

    // Ordering: mem older than alu to the same register
    wlog.delete();
    drive(1, 5'd3, 32'hAAAA0001, 1, 5'd3, 32'h00000002);
    tick();
    idle();
    chk("ord_count",  count,     2);
    chk("ord_w1",     writeData, 32'hAAAA0001);
    chk("ord_peek1",  peekData,  32'h00000002);
    tick();
    chk("ord_w2",     writeData, 32'h00000002);
    chk("ord_peek2",  peekData,  32'h00000002);
    tick();
    chk("ord_empty",  regWrite,  0);
    chk("ord_nopeek", peekHit,   0);
    chk("ord_logsz",  wlog.size(), 2);
    if (wlog.size() == 2) begin
      chk("ord_log0", {wlog[0].r, wlog[0].d}, {5'd3, 32'hAAAA0001});
      chk("ord_log1", {wlog[1].r, wlog[1].d}, {5'd3, 32'h00000002});
    end

    // r0 filter
    drive(0, 0, 0, 1, 5'd0, 32'hFFFFFFFF);
    tick();
    idle();
    chk("r0_count",    count,    0);
    chk("r0_regWrite", regWrite, 0);
    tick();

    // Fill with two requests per cycle, stalling on inReady
    wlog.delete();
    idx = 0;
    for (int c = 0; c < 40 && (idx < 6 || mq.size() != 0); c++) begin
      if (inReady && idx < 6) begin
        drive(1, AW'(idx + 1), 32'h10000000 | (idx + 1), 1, AW'(idx + 2), 32'h10000000 | (idx + 2));
        idx += 2;
      end else idle();
      tick();
      if (c == 0) chk("fill_c0_count", count, 2);
      if (c == 1) begin
        chk("fill_c1_count",   count,   3);
        chk("fill_c1_inReady", inReady, 0);
      end
    end
    idle();
    chk("fill_done", (idx == 6) && (mq.size() == 0), 1);
    chk("fill_logsz", wlog.size(), 6);
    for (int i = 0; i < wlog.size() && i < 6; i++) begin
      chk("fill_reg",  wlog[i].r, i + 1);
      chk("fill_data", wlog[i].d, 32'h10000000 | (i + 1));
    end

    // Drop while not ready
    wlog.delete();
    drive(1, 5'd7, 32'h7, 1, 5'd8, 32'h8);
    tick();
    drive(1, 5'd9, 32'h9, 1, 5'd10, 32'hA);
    tick();
    chk("drop_count", count, 3);
    chk("drop_inReady", inReady, 0);
    drive(0, 0, 0, 1, 5'd5, 32'h55);
    tick();
    idle();
`ifdef WBQ_OVERFLOW_ERR_EN
    chk("ovf_set", overflowErr, 1);
`endif
    for (int c = 0; c < 5; c++) tick();
`ifdef WBQ_OVERFLOW_ERR_EN
    chk("ovf_sticky", overflowErr, 1);
`endif
    chk("drop_logsz", wlog.size(), 4);
    for (int i = 0; i < wlog.size(); i++) begin
      chk("drop_no_r5", wlog[i].r == 5, 0);
      chk("drop_reg",   wlog[i].r, i + 7);
    end

    // Reset mid-operation
    drive(1, 5'd11, 32'hB, 1, 5'd12, 32'hC);
    tick();
    drive(1, 5'd13, 32'hD, 1, 5'd14, 32'hE);
    tick();
    idle();
    chk("mrst_pre_count", count, 3);
    Reset_n = 0;
    tick();
    chk("mrst_regWrite", regWrite, 0);
    chk("mrst_count",    count,    0);
`ifdef WBQ_OVERFLOW_ERR_EN
    chk("mrst_ovf", overflowErr, 0);
`endif
    Reset_n = 1;
    wlog.delete();
    for (int c = 0; c < 5; c++) tick();
    chk("mrst_nowrites", wlog.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
